// File: rtl/ahb_lite_cmd_master.sv
// AHB-Lite single-transfer master: valid/ready commands in, pipelined address and
// data phases on the bus, in-order responses out through a MAX_OUT-deep FIFO.
module ahb_lite_cmd_master #(
   parameter int MAX_OUT = 2
) (
   input  logic        HCLK,
   input  logic        HRESET,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic        cmd_write,
   input  logic [31:0] cmd_addr,
   input  logic [2:0]  cmd_size,
   input  logic        cmd_data,
   input  logic [63:0] cmd_wdata,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [63:0] rsp_rdata,
   output logic        rsp_err,
   output logic        rsp_write,
   output logic        HSEL,
   output logic [31:0] HADDR,
   output logic [1:0]  HTRANS,
   output logic        HWRITE,
   output logic [2:0]  HSIZE,
   output logic [2:0]  HBURST,
   output logic [3:0]  HPROT,
   output logic [63:0] HWDATA,
   input  logic [63:0] HRDATA,
   input  logic        HREADY,
   input  logic        HRESP
);
   localparam int CW = $clog2(MAX_OUT + 1);
   localparam int PW = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;

   typedef struct packed {
      logic [63:0] rdata;
      logic        err;
      logic        write;
   } rsp_t;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(MAX_OUT - 1)) ? '0 : p + PW'(1);
   endfunction

   logic              ap_valid_q, ap_valid_d;
   logic [31:0]       ap_addr_q, ap_addr_d;
   logic              ap_write_q, ap_write_d;
   logic [2:0]        ap_size_q, ap_size_d;
   logic              ap_data_q, ap_data_d;
   logic [63:0]       ap_wdata_q, ap_wdata_d;
   logic              dp_valid_q, dp_valid_d;
   logic              dp_write_q, dp_write_d;
   logic [63:0]       hwdata_q, hwdata_d;
   logic              err_q, err_d;
   logic [CW-1:0]     infl_q, infl_d;
   logic              hsel_q;
   rsp_t [MAX_OUT-1:0] fifo_q, fifo_d;
   logic [PW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]     cnt_q, cnt_d;

   logic cmd_accept, ap_done, dp_done, rsp_pop, cmd_legal;
   rsp_t push_ent, head;

   assign cmd_ready  = (infl_q < CW'(MAX_OUT)) & (~ap_valid_q | HREADY);
   assign cmd_accept = cmd_valid & cmd_ready;
   assign ap_done    = ap_valid_q & HREADY;
   assign dp_done    = dp_valid_q & HREADY;
   assign rsp_pop    = rsp_valid & rsp_ready;

   always_comb begin
      ap_valid_d = ap_valid_q;
      ap_addr_d  = ap_addr_q;
      ap_write_d = ap_write_q;
      ap_size_d  = ap_size_q;
      ap_data_d  = ap_data_q;
      ap_wdata_d = ap_wdata_q;
      if (ap_done) ap_valid_d = 1'b0;
      if (cmd_accept) begin
         ap_valid_d = 1'b1;
         ap_addr_d  = cmd_addr;
         ap_write_d = cmd_write;
         ap_size_d  = cmd_size;
         ap_data_d  = cmd_data;
         ap_wdata_d = cmd_wdata;
      end

      // Error flag covers the ERROR cycle with HREADY low; the final cycle adds HRESP directly.
      push_ent.rdata = dp_write_q ? 64'd0 : HRDATA;
      push_ent.err   = err_q | HRESP;
      push_ent.write = dp_write_q;

      dp_valid_d = dp_valid_q;
      dp_write_d = dp_write_q;
      hwdata_d   = hwdata_q;
      err_d      = err_q;
      if (dp_valid_q && HRESP && !HREADY) err_d = 1'b1;
      if (dp_done) begin
         dp_valid_d = 1'b0;
         err_d      = 1'b0;
      end
      if (ap_done) begin
         dp_valid_d = 1'b1;
         dp_write_d = ap_write_q;
         if (ap_write_q) hwdata_d = ap_wdata_q;
      end

      infl_d = infl_q;
      case ({cmd_accept, rsp_pop})
         2'b10:   infl_d = infl_q + CW'(1);
         2'b01:   infl_d = infl_q - CW'(1);
         default: infl_d = infl_q;
      endcase

      fifo_d   = fifo_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (dp_done) begin
         fifo_d[wr_ptr_q] = push_ent;
         wr_ptr_d         = ptr_inc(wr_ptr_q);
      end
      if (rsp_pop) rd_ptr_d = ptr_inc(rd_ptr_q);
      cnt_d = cnt_q + CW'(dp_done) - CW'(rsp_pop);
   end

   always_ff @(posedge HCLK or posedge HRESET) begin
      if (HRESET) begin
         ap_valid_q <= 1'b0;
         ap_addr_q  <= '0;
         ap_write_q <= 1'b0;
         ap_size_q  <= '0;
         ap_data_q  <= 1'b0;
         ap_wdata_q <= '0;
         dp_valid_q <= 1'b0;
         dp_write_q <= 1'b0;
         hwdata_q   <= '0;
         err_q      <= 1'b0;
         infl_q     <= '0;
         hsel_q     <= 1'b0;
         fifo_q     <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         cnt_q      <= '0;
      end else begin
         ap_valid_q <= ap_valid_d;
         ap_addr_q  <= ap_addr_d;
         ap_write_q <= ap_write_d;
         ap_size_q  <= ap_size_d;
         ap_data_q  <= ap_data_d;
         ap_wdata_q <= ap_wdata_d;
         dp_valid_q <= dp_valid_d;
         dp_write_q <= dp_write_d;
         hwdata_q   <= hwdata_d;
         err_q      <= err_d;
         infl_q     <= infl_d;
         hsel_q     <= 1'b1;
         fifo_q     <= fifo_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         cnt_q      <= cnt_d;
      end
   end

   assign head      = fifo_q[rd_ptr_q];
   assign rsp_valid = (cnt_q != '0);
   assign rsp_rdata = head.rdata;
   assign rsp_err   = head.err;
   assign rsp_write = head.write;

   assign HSEL   = hsel_q;
   assign HTRANS = ap_valid_q ? 2'b10 : 2'b00;
   assign HADDR  = ap_addr_q;
   assign HWRITE = ap_write_q;
   assign HSIZE  = ap_size_q;
   assign HBURST = 3'b000;
   assign HPROT  = {3'b001, ap_data_q};
   assign HWDATA = hwdata_q;

   assign cmd_legal = (cmd_size <= 3'd3) &&
                      ((cmd_addr & ((32'd1 << cmd_size) - 32'd1)) == 32'd0);

   assert property (@(posedge HCLK) disable iff (HRESET) (cmd_valid && cmd_ready) |-> cmd_legal);

endmodule

// File: tb/tb_ahb_lite_cmd_master.sv
// Bench for ahb_lite_cmd_master: AHB-Lite slave memory with scripted wait/error
// responses, and a transaction-level scoreboard predicting every response.
module tb_ahb_lite_cmd_master;
   localparam int MAX_OUT = 2;
   localparam int NW = 2048;

   logic        HCLK = 1'b0;
   logic        HRESET = 1'b1;
   logic        cmd_valid, cmd_ready, cmd_write, cmd_data;
   logic [31:0] cmd_addr;
   logic [2:0]  cmd_size;
   logic [63:0] cmd_wdata;
   logic        rsp_valid, rsp_ready, rsp_err, rsp_write;
   logic [63:0] rsp_rdata;
   logic        HSEL, HWRITE, HREADY, HRESP;
   logic [31:0] HADDR;
   logic [1:0]  HTRANS;
   logic [2:0]  HSIZE, HBURST;
   logic [3:0]  HPROT;
   logic [63:0] HWDATA, HRDATA;

   always #5 HCLK = ~HCLK;

   ahb_lite_cmd_master #(.MAX_OUT(MAX_OUT)) dut (
      .HCLK(HCLK), .HRESET(HRESET),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_addr(cmd_addr), .cmd_size(cmd_size), .cmd_data(cmd_data), .cmd_wdata(cmd_wdata),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
      .rsp_err(rsp_err), .rsp_write(rsp_write),
      .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE),
      .HBURST(HBURST), .HPROT(HPROT), .HWDATA(HWDATA), .HRDATA(HRDATA),
      .HREADY(HREADY), .HRESP(HRESP)
   );

   typedef struct {
      logic        write;
      logic [31:0] addr;
      logic [2:0]  size;
      logic        data;
      logic [63:0] wdata;
      int          waits;
      logic        err;
   } cmd_t;

   typedef struct {
      logic [63:0] rdata;
      logic        err;
      logic        write;
   } rsp_t;

   cmd_t        cmd_q[$];
   rsp_t        exp_q[$];
   cmd_t        ap_cmd;
   logic        ap_busy;
   logic [63:0] smem [0:NW-1];
   logic [63:0] rmem [0:NW-1];
   int          cfg_wait [0:4095];
   logic        cfg_err  [0:4095];
   int          acc_cnt, pop_cnt, n_assert, n_fail;
   int          stall_cnt, nonseq_cnt, err_rsp_cnt;
   int unsigned gap_pct;
   int          rr_mode;
   logic [63:0] last_rdata;

   function automatic logic [63:0] pat(input int i);
      return {32'hA5A5_0000 | 32'(i), ~32'(i * 7)};
   endfunction

   function automatic logic [63:0] merge(input logic [63:0] old, input logic [63:0] nw,
                                         input logic [31:0] a, input logic [2:0] sz);
      logic [63:0] r;
      int lo, n;
      r  = old;
      lo = int'(a[2:0]);
      n  = 1 << sz;
      for (int b = 0; b < 8; b++)
         if (b >= lo && b < lo + n) r[8*b +: 8] = nw[8*b +: 8];
      return r;
   endfunction

   function automatic cmd_t mk(input logic w, input logic [31:0] a, input logic [2:0] s,
                               input logic [63:0] d, input int wt, input logic e);
      cmd_t c;
      c.write = w; c.addr = a; c.size = s; c.data = 1'b1;
      c.wdata = d; c.waits = wt; c.err = e;
      return c;
   endfunction

   // Slave: one data phase at a time, waits/error scripted per accepted command.
   logic        s_act, s_wr, s_err;
   logic [31:0] s_addr;
   logic [2:0]  s_size;
   int          s_cnt, s_idx;

   assign HREADY = !s_act || (s_cnt == 0);
   assign HRESP  = s_act && s_err && (s_cnt <= 1);
   assign HRDATA = (s_act && !s_wr && s_cnt == 0) ? smem[s_addr[13:3]] : 64'hBAD0_BAD0_BAD0_BAD0;

   always @(posedge HCLK or posedge HRESET) begin
      if (HRESET) begin
         s_act <= 1'b0; s_wr <= 1'b0; s_err <= 1'b0; s_cnt <= 0;
         s_addr <= '0; s_size <= '0; s_idx <= acc_cnt;
      end else if (HREADY) begin
         if (s_act && s_wr && !s_err)
            smem[s_addr[13:3]] <= merge(smem[s_addr[13:3]], HWDATA, s_addr, s_size);
         s_act <= (HTRANS == 2'b10);
         if (HTRANS == 2'b10) begin
            s_addr <= HADDR; s_wr <= HWRITE; s_size <= HSIZE;
            s_cnt  <= cfg_wait[s_idx % 4096] + (cfg_err[s_idx % 4096] ? 1 : 0);
            s_err  <= cfg_err[s_idx % 4096];
            s_idx  <= s_idx + 1;
         end
      end else begin
         s_cnt <= s_cnt - 1;
      end
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic present();
      if (cmd_q.size() > 0 && $urandom_range(99) >= gap_pct) begin
         cmd_valid = 1'b1;
         cmd_write = cmd_q[0].write;
         cmd_addr  = cmd_q[0].addr;
         cmd_size  = cmd_q[0].size;
         cmd_data  = cmd_q[0].data;
         cmd_wdata = cmd_q[0].wdata;
      end else begin
         cmd_valid = 1'b0;
      end
      case (rr_mode)
         0:       rsp_ready = 1'b0;
         1:       rsp_ready = 1'b1;
         default: rsp_ready = 1'($urandom_range(1));
      endcase
   endtask

   // One bus cycle: observe at the falling edge, update the model, drive after the rising edge.
   task automatic cyc();
      logic acc;
      cmd_t c;
      rsp_t e;
      @(negedge HCLK);
      chk("hsel", HSEL, 1);
      chk("hburst", HBURST, 0);
      chk("htrans", HTRANS, ap_busy ? 2'b10 : 2'b00);
      chk("cmd_ready", cmd_ready, ((acc_cnt - pop_cnt) < MAX_OUT) && (!ap_busy || HREADY));
      if (ap_busy) begin
         chk("haddr", HADDR, ap_cmd.addr);
         chk("hwrite", HWRITE, ap_cmd.write);
         chk("hsize", HSIZE, ap_cmd.size);
         chk("hprot", HPROT, {3'b001, ap_cmd.data});
         nonseq_cnt++;
         if (!HREADY) stall_cnt++;
      end
      if (rsp_valid && rsp_ready) begin
         if (exp_q.size() == 0) chk("rsp_unexpected", 1, 0);
         else begin
            e = exp_q.pop_front();
            chk("rsp_rdata", rsp_rdata, e.rdata);
            chk("rsp_err", rsp_err, e.err);
            chk("rsp_write", rsp_write, e.write);
            if (!rsp_write) last_rdata = rsp_rdata;
            if (rsp_err) err_rsp_cnt++;
         end
         pop_cnt++;
      end
      acc = cmd_valid && cmd_ready;
      if (acc) begin
         c = cmd_q[0];
         e.write = c.write;
         e.err   = c.err;
         e.rdata = c.write ? 64'd0 : rmem[c.addr[13:3]];
         if (c.write && !c.err) rmem[c.addr[13:3]] = merge(rmem[c.addr[13:3]], c.wdata, c.addr, c.size);
         exp_q.push_back(e);
         cfg_wait[acc_cnt % 4096] = c.waits;
         cfg_err[acc_cnt % 4096]  = c.err;
         acc_cnt++;
         ap_cmd = c;
      end
      ap_busy = acc ? 1'b1 : ((ap_busy && HREADY) ? 1'b0 : ap_busy);
      @(posedge HCLK);
      #1;
      if (acc) cmd_q.delete(0);
      present();
   endtask

   task automatic drain(input int budget);
      int n;
      n = 0;
      while ((cmd_q.size() > 0 || exp_q.size() > 0) && n < budget) begin
         cyc();
         n++;
      end
      chk("drain_done", (cmd_q.size() == 0 && exp_q.size() == 0), 1);
   endtask

   initial begin
      int s0, a0, p0, e0;
      cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_size = 0; cmd_data = 0;
      cmd_wdata = 0; rsp_ready = 0;
      acc_cnt = 0; pop_cnt = 0; n_assert = 0; n_fail = 0;
      stall_cnt = 0; nonseq_cnt = 0; err_rsp_cnt = 0;
      gap_pct = 0; rr_mode = 1; ap_busy = 1'b0; last_rdata = '0;
      for (int i = 0; i < NW; i++) begin
         smem[i] <= pat(i);
         rmem[i] = pat(i);
      end
      for (int i = 0; i < 4096; i++) begin
         cfg_wait[i] = 0;
         cfg_err[i]  = 1'b0;
      end

      // Reset values
      #12;
      chk("rst_htrans", HTRANS, 2'b00);
      chk("rst_haddr", HADDR, 0);
      chk("rst_hwrite", HWRITE, 0);
      chk("rst_hsize", HSIZE, 0);
      chk("rst_hprot", HPROT, 4'b0010);
      chk("rst_hwdata", HWDATA, 0);
      chk("rst_hsel", HSEL, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_rsp_rdata", rsp_rdata, 0);
      chk("rst_rsp_err", rsp_err, 0);
      chk("rst_rsp_write", rsp_write, 0);
      chk("rst_cmd_ready", cmd_ready, 1);
      @(negedge HCLK);
      HRESET = 1'b0;
      #2;
      chk("hsel_before_clk", HSEL, 0);
      @(posedge HCLK);
      #1;
      chk("hsel_after_clk", HSEL, 1);

      // Full-width write then read, zero wait states
      s0 = stall_cnt; a0 = nonseq_cnt;
      cmd_q.push_back(mk(1, 32'h1000, 3'd3, 64'h1122_3344_5566_7788, 0, 0));
      cmd_q.push_back(mk(0, 32'h1000, 3'd3, 64'd0, 0, 0));
      present();
      drain(50);
      chk("t1_nonseq_cycles", nonseq_cnt - a0, 2);
      chk("t1_stalls", stall_cnt - s0, 0);
      chk("t1_rdata", last_rdata, 64'h1122_3344_5566_7788);

      // Byte write into lane 3
      cmd_q.push_back(mk(1, 32'h1003, 3'd0, 64'hAB << 24, 0, 0));
      cmd_q.push_back(mk(0, 32'h1000, 3'd3, 64'd0, 0, 0));
      present();
      drain(50);
      chk("t2_rdata", last_rdata, 64'h1122_3344_AB66_7788);

      // Wait states stall the pipelined address phase
      s0 = stall_cnt;
      cmd_q.push_back(mk(0, 32'h1000, 3'd3, 64'd0, 3, 0));
      cmd_q.push_back(mk(0, 32'h1008, 3'd3, 64'd0, 0, 0));
      present();
      drain(50);
      chk("t3_stall_cycles", stall_cnt - s0, 3);

      // Response back-pressure limits commands in flight
      a0 = acc_cnt; p0 = pop_cnt;
      rr_mode = 0;
      cmd_q.push_back(mk(1, 32'h1010, 3'd3, 64'h0F0E_0D0C_0B0A_0908, 0, 0));
      cmd_q.push_back(mk(0, 32'h1010, 3'd3, 64'd0, 0, 0));
      cmd_q.push_back(mk(0, 32'h1000, 3'd2, 64'd0, 0, 0));
      present();
      repeat (8) cyc();
      chk("t4_accepted_2", acc_cnt - a0, 2);
      chk("t4_ready_low", cmd_ready, 0);
      rr_mode = 1; rsp_ready = 1'b1;
      cyc();
      rr_mode = 0; rsp_ready = 1'b0;
      repeat (4) cyc();
      chk("t4_accepted_3", acc_cnt - a0, 3);
      chk("t4_popped_1", pop_cnt - p0, 1);
      rr_mode = 1;
      drain(50);

      // Two-cycle ERROR on a read; the pipelined read behind it is clean
      e0 = err_rsp_cnt;
      cmd_q.push_back(mk(0, 32'h2000, 3'd3, 64'd0, 0, 1));
      cmd_q.push_back(mk(0, 32'h2008, 3'd3, 64'd0, 0, 0));
      present();
      drain(50);
      chk("t5_err_count", err_rsp_cnt - e0, 1);

      // Asynchronous reset during a wait-stated read data phase
      rr_mode = 0;
      cmd_q.push_back(mk(1, 32'h1018, 3'd3, 64'hCAFE_F00D_1234_5678, 0, 0));
      cmd_q.push_back(mk(0, 32'h1000, 3'd3, 64'd0, 6, 0));
      present();
      for (int i = 0; i < 20 && !(s_act && !s_wr && !HREADY); i++) cyc();
      chk("t6_in_stall", (s_act && !s_wr && !HREADY), 1);
      chk("t6_rsp_valid_pre", rsp_valid, 1);
      #2;
      HRESET = 1'b1;
      #1;
      chk("t6_htrans_rst", HTRANS, 2'b00);
      chk("t6_rsp_valid_rst", rsp_valid, 0);
      chk("t6_cmd_ready_rst", cmd_ready, 1);
      cmd_q.delete(); exp_q.delete();
      pop_cnt = acc_cnt; ap_busy = 1'b0;
      cmd_valid = 1'b0; rsp_ready = 1'b0;
      repeat (2) @(posedge HCLK);
      @(negedge HCLK);
      HRESET = 1'b0;
      @(posedge HCLK);
      #1;
      rr_mode = 1;
      cmd_q.push_back(mk(0, 32'h1000, 3'd3, 64'd0, 0, 0));
      present();
      drain(50);
      chk("t6_rdata_after", last_rdata, 64'h1122_3344_AB66_7788);

      // Randomized traffic against the scoreboard
      rr_mode = 2; gap_pct = 30;
      for (int i = 0; i < 150; i++) begin
         cmd_t c;
         int off;
         c.write = 1'($urandom_range(1));
         c.size  = 3'($urandom_range(3));
         off     = int'($urandom_range(7));
         off     = (off >> c.size) << c.size;
         c.addr  = 32'h1000 + (32'($urandom_range(255)) << 3) + 32'(off);
         c.data  = 1'($urandom_range(1));
         c.wdata = {$urandom, $urandom};
         c.waits = ($urandom_range(1) == 0) ? 0 : int'($urandom_range(3));
         c.err   = ($urandom_range(7) == 0);
         cmd_q.push_back(c);
      end
      present();
      drain(5000);
      chk("final_exp_empty", exp_q.size(), 0);
      chk("final_infl_zero", acc_cnt - pop_cnt, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
